sonar_ranger: RTL and testbench

- Multi-channel ultrasonic ranging controller for HC-SR04-class sensors on the car.
- Fires the trigger of each channel in round-robin slots and times each echo pulse with a 1 µs tick derived from clk; no generated clocks.
- Converts echo width to whole centimetres without a divider and publishes per-channel distance, a valid strobe and timeout status.
- Drives a per-channel obstacle flag with programmable threshold and hysteresis, which feeds the motor stop logic.

---
 rtl/sonar_ranger_if.sv | 24 ++
 rtl/sonar_ranger.sv | 120 ++++++++++++
 tb/tb_sonar_ranger.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sonar_ranger_if.sv
// sonar_ranger_if: control and result bundle between the ranging controller and the vehicle logic
// master: the ranging controller (drives trig and results); slave: the vehicle side (drives en, echo, threshold)
interface sonar_ranger_if #(
  parameter int CHANNELS = 2,
  parameter int DIST_W = 10
);
  logic en;
  logic [CHANNELS-1:0] echo;
  logic [DIST_W-1:0] near_th_cm;
  logic [CHANNELS-1:0] trig;
  logic [CHANNELS*DIST_W-1:0] dist_cm;
  logic dist_valid;
  logic [2:0] dist_ch;
  logic [CHANNELS-1:0] timeout;
  logic [CHANNELS-1:0] near;
  modport master (
    input en, echo, near_th_cm,
    output trig, dist_cm, dist_valid, dist_ch, timeout, near
  );
  modport slave (
    output en, echo, near_th_cm,
    input trig, dist_cm, dist_valid, dist_ch, timeout, near
  );
endinterface

// File: rtl/sonar_ranger.sv
// sonar_ranger: round-robin ultrasonic ranging with echo timing, cm conversion and obstacle flags
// clk, rst (async, active-high); bus.master: en, echo, near_th_cm in; trig, dist_cm, dist_valid, dist_ch, timeout, near out
module sonar_ranger #(
  parameter int CLK_HZ = 100000000,
  parameter int CHANNELS = 2,
  parameter int DIST_W = 10,
  parameter int TRIG_US = 10,
  parameter int SLOT_US = 60000,
  parameter int TIMEOUT_US = 30000,
  parameter int HYST_CM = 5
) (
  input logic clk,
  input logic rst,
  sonar_ranger_if.master bus
);
  localparam int TICK = CLK_HZ / 1000000;
  localparam int PW = TICK > 1 ? $clog2(TICK) : 1;
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int SW = $clog2(SLOT_US + 1);
  localparam int TW = $clog2((TRIG_US > TIMEOUT_US ? TRIG_US : TIMEOUT_US) + 1);
  localparam logic [DIST_W-1:0] DMAX = '1;
  localparam logic [DIST_W:0] HYST = (DIST_W+1)'(HYST_CM);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE, GAP} state_t;
  state_t state, nxt;
  logic [PW-1:0] pre;
  logic us_tick;
  logic [CHANNELS-1:0] s1, s2, s3;
  logic rise_q, fall_q;
  logic [CW-1:0] ptr, ptr_n;
  logic [SW-1:0] slot;
  logic [TW-1:0] tcnt;
  logic [5:0] sub, sub_n;
  logic [DIST_W-1:0] cm, cm_n, res;
  logic to_n;
  logic [CHANNELS-1:0] trig_q, to_q, near_q;
  logic [CHANNELS*DIST_W-1:0] dist_q;
  assign us_tick = pre == PW'(TICK - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) pre <= '0;
    else pre <= us_tick ? '0 : pre + 1'b1;
  // s3 is the previous synchronised sample; edges of the selected channel are registered once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1 <= bus.echo;
      s2 <= s1;
      s3 <= s2;
      rise_q <= s2[ptr] & ~s3[ptr];
      fall_q <= ~s2[ptr] & s3[ptr];
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    to_n = 1'b0;
    case (state)
      IDLE: if (us_tick && bus.en) nxt = TRIG;
      TRIG: if (us_tick && tcnt == TW'(TRIG_US - 1)) nxt = WAIT_RISE;
      WAIT_RISE:
        if (rise_q) nxt = MEASURE;
        else if (us_tick && tcnt == TW'(TIMEOUT_US - 1)) begin
          nxt = DONE;
          to_n = 1'b1;
        end
      MEASURE:
        if (fall_q) nxt = DONE;
        else if (us_tick && tcnt == TW'(TIMEOUT_US - 1)) begin
          nxt = DONE;
          to_n = 1'b1;
        end
      DONE: nxt = GAP;
      GAP: if (us_tick && slot >= SW'(SLOT_US - 1)) nxt = bus.en ? TRIG : IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign ptr_n = ptr == CW'(CHANNELS - 1) ? '0 : ptr + 1'b1;
  assign sub_n = us_tick ? (sub == 6'd57 ? 6'd0 : sub + 6'd1) : sub;
  // result uses this cycle's count so a fall on a 58 us boundary is not lost
  assign cm_n = us_tick && sub == 6'd57 && cm != DMAX ? cm + 1'b1 : cm;
  assign res = to_n ? DMAX : cm_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      slot <= '0;
      tcnt <= '0;
      sub <= '0;
      cm <= '0;
      trig_q <= '0;
      dist_q <= '1;
      to_q <= '0;
      near_q <= '1;
    end else begin
      slot <= nxt == TRIG && state != TRIG ? '0 : us_tick && slot != SW'(SLOT_US) ? slot + 1'b1 : slot;
      tcnt <= nxt != state ? '0 : tcnt + TW'(us_tick);
      sub <= state == MEASURE ? sub_n : '0;
      cm <= state == MEASURE ? cm_n : '0;
      if (state == GAP && nxt != GAP) ptr <= ptr_n;
      trig_q <= nxt == TRIG ? CHANNELS'(1) << (state == GAP ? ptr_n : ptr) : '0;
      if (nxt == DONE) begin
        dist_q[ptr*DIST_W +: DIST_W] <= res;
        to_q[ptr] <= to_n;
        near_q[ptr] <= to_n ? 1'b0 : res < bus.near_th_cm ? 1'b1 :
                       {1'b0, res} >= {1'b0, bus.near_th_cm} + HYST ? 1'b0 : near_q[ptr];
      end
    end
  assign bus.trig = trig_q;
  assign bus.dist_cm = dist_q;
  assign bus.timeout = to_q;
  assign bus.near = near_q;
  always_comb begin
    bus.dist_valid = state == DONE;
    bus.dist_ch = 3'(ptr);
  end
endmodule

// File: tb/tb_sonar_ranger.sv
// tb_sonar_ranger: directed ranging scenarios checked every cycle against a slot-timing and arithmetic model
`timescale 1ns/1ps
module tb_sonar_ranger;
  localparam int CH = 2, DW = 10, TRIG = 10, SLOT = 3000, TMO = 2700, HYST = 5;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, n_vec = 0, n_bad = 0, th = 35;
  logic [CH-1:0] exp_trig, exp_to, exp_near;
  logic exp_valid;
  logic [2:0] exp_ch;
  logic [DW-1:0] exp_dist [CH];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sonar_ranger_if #(.CHANNELS(CH), .DIST_W(DW)) bus ();
  sonar_ranger_if #(.CHANNELS(1), .DIST_W(4)) sbus ();
  sonar_ranger #(.CLK_HZ(1000000), .CHANNELS(CH), .DIST_W(DW), .TRIG_US(TRIG), .SLOT_US(SLOT),
    .TIMEOUT_US(TMO), .HYST_CM(HYST)) dut (.clk(clk), .rst(rst), .bus(bus));
  sonar_ranger #(.CLK_HZ(3000000), .CHANNELS(1), .DIST_W(4), .TRIG_US(TRIG), .SLOT_US(1500),
    .TIMEOUT_US(1400), .HYST_CM(HYST)) sdut (.clk(clk), .rst(rst), .bus(sbus));
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < CH; k++) exp_dist[k] = '1;
    exp_to = '0;
    exp_near = '1;
    exp_trig = '0;
    exp_valid = 1'b0;
    exp_ch = '0;
  endtask
  // w < 0 means the measurement timed out
  task automatic model_result(int ch, int w);
    logic [DW-1:0] d;
    d = w < 0 ? '1 : DW'(w / 58 > 1023 ? 1023 : w / 58);
    exp_dist[ch] = d;
    exp_to[ch] = w < 0;
    exp_near[ch] = w < 0 ? 1'b0 : int'(d) < th ? 1'b1 : int'(d) >= th + HYST ? 1'b0 : exp_near[ch];
    exp_ch = 3'(ch);
  endtask
  task automatic wait_to(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask
  // one slot whose trigger is visible from cycle t0; echo of ch high for cycles [es, es+w) of the slot
  task automatic run_slot(int t0, int ch, int es, int w, bit noise, int drop_at, int rst_at);
    bit ok = w > 0 && es >= TRIG;
    int v = ok ? (w < TMO ? es + w + 4 : es + 4 + TMO) : TRIG + TMO;
    int r = ok && w < TMO ? w : -1;
    for (int i = 0; i < SLOT; i++) begin
      wait_to(t0 + i);
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_trig", 32'(bus.trig), 0);
        chk("rst_near", 32'(bus.near), 32'h3);
        chk("rst_dist", 32'(bus.dist_cm), 32'hFFFFF);
        chk("rst_timeout", 32'(bus.timeout), 0);
        model_reset();
        bus.en = 1'b0;
        bus.echo = '0;
        return;
      end
      exp_trig = i < TRIG ? CH'(1) << ch : '0;
      bus.echo = ((w > 0 && i >= es && i < es + w) ? CH'(1) << ch : '0) |
                 ((noise && i >= 300 && i < 900) ? CH'(1) << (1 - ch) : '0);
      if (i == drop_at) bus.en = 1'b0;
      exp_valid = i == v;
      if (i == v) model_result(ch, r);
    end
  endtask
  always @(negedge clk) begin
    chk("trig", 32'(bus.trig), 32'(exp_trig));
    chk("dist_valid", 32'(bus.dist_valid), 32'(exp_valid));
    if (exp_valid) chk("dist_ch", 32'(bus.dist_ch), 32'(exp_ch));
    for (int k = 0; k < CH; k++) chk("dist_cm", 32'(bus.dist_cm[k*DW +: DW]), 32'(exp_dist[k]));
    chk("timeout", 32'(bus.timeout), 32'(exp_to));
    chk("near", 32'(bus.near), 32'(exp_near));
  end
  initial begin
    int t, k;
    model_reset();
    bus.en = 1'b0;
    bus.echo = '0;
    bus.near_th_cm = DW'(th);
    sbus.en = 1'b0;
    sbus.echo = '0;
    sbus.near_th_cm = 4'd10;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_near", 32'(bus.near), 32'h3);
    chk("reset_dist", 32'(bus.dist_cm), 32'hFFFFF);
    t = cyc + 2;
    wait_to(t - 1);
    bus.en = 1'b1;
    run_slot(t, 0, 210, 2320, 0, -1, -1);
    chk("w2320_dist", 32'(bus.dist_cm[9:0]), 40);
    chk("w2320_near", 32'(bus.near[0]), 0);
    run_slot(t + SLOT, 1, 0, 0, 0, -1, -1);
    chk("noecho_dist", 32'(bus.dist_cm[19:10]), 32'h3FF);
    chk("noecho_timeout", 32'(bus.timeout), 32'h2);
    th = 40;
    bus.near_th_cm = DW'(th);
    run_slot(t + 2 * SLOT, 0, 210, 2319, 1, -1, -1);
    chk("w2319_dist", 32'(bus.dist_cm[9:0]), 39);
    chk("w2319_near", 32'(bus.near[0]), 1);
    run_slot(t + 3 * SLOT, 1, 210, 580, 0, -1, -1);
    chk("recover_timeout", 32'(bus.timeout), 0);
    run_slot(t + 4 * SLOT, 0, 210, 2436, 0, -1, -1);
    chk("w2436_near_hold", 32'(bus.near[0]), 1);
    run_slot(t + 5 * SLOT, 1, 2, 398, 0, -1, -1);
    run_slot(t + 6 * SLOT, 0, 210, 2610, 0, 300, -1);
    chk("w2610_dist", 32'(bus.dist_cm[9:0]), 45);
    chk("w2610_near", 32'(bus.near[0]), 0);
    wait_to(cyc + 400);
    t = cyc + 2;
    wait_to(t - 1);
    bus.en = 1'b1;
    run_slot(t, 1, 210, 1160, 0, -1, -1);
    run_slot(t + SLOT, 0, 10, 2900, 0, -1, -1);
    chk("long_echo_timeout", 32'(bus.timeout[0]), 1);
    run_slot(t + 2 * SLOT, 1, 210, 2000, 0, -1, 1000);
    wait_to(cyc + 2);
    rst = 1'b0;
    t = cyc + 2;
    wait_to(t - 1);
    bus.en = 1'b1;
    run_slot(t, 0, 210, 1740, 0, -1, 5);
    wait_to(cyc + 2);
    rst = 1'b0;
    t = cyc + 2;
    wait_to(t - 1);
    bus.en = 1'b1;
    run_slot(t, 0, 210, 1740, 0, 2900, -1);
    chk("w1740_dist", 32'(bus.dist_cm[9:0]), 30);
    chk("s_reset_near", 32'(sbus.near), 1);
    sbus.en = 1'b1;
    k = 0;
    while (!sbus.trig[0] && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("s_trig_seen", 32'(sbus.trig), 1);
    k = 0;
    while (sbus.trig[0] && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("s_trig_width", k, 30);
    sbus.en = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    sbus.echo = 1'b1;
    repeat (3600) @(posedge clk);
    #1;
    sbus.echo = 1'b0;
    k = 0;
    while (!sbus.dist_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("s_latency", k, 4);
    chk("s_sat_dist", 32'(sbus.dist_cm), 15);
    chk("s_sat_timeout", 32'(sbus.timeout), 0);
    chk("s_sat_near", 32'(sbus.near), 0);
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
